// File: rtl/bp_axi_router_pkg.sv
// Shared types and AXI response codes for the AXI read router.
package bp_axi_router_pkg;

  typedef enum logic [1:0] {
    e_ready  = 2'd0,
    e_target = 2'd1,
    e_decerr = 2'd2
  } state_e;

  localparam logic [1:0] axi_resp_okay_lp   = 2'b00;
  localparam logic [1:0] axi_resp_decerr_lp = 2'b11;

endpackage

// File: rtl/bp_axi_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching target wins.
module bp_axi_addr_decode #(
  parameter int num_targets_p = 2,
  parameter int addr_width_p  = 64,
  parameter int sel_width_p   = 1,
  parameter logic [num_targets_p-1:0][addr_width_p-1:0] base_p = '0,
  parameter logic [num_targets_p-1:0][addr_width_p-1:0] mask_p = '0
) (
  input  logic [addr_width_p-1:0]  addr,
  output logic [num_targets_p-1:0] match_oh,
  output logic [sel_width_p-1:0]   sel,
  output logic                     hit
);

  always_comb begin
    match_oh = '0;
    sel      = '0;
    hit      = 1'b0;
    for (int i = 0; i < num_targets_p; i++) begin
      if (!hit && ((addr & mask_p[i]) == (base_p[i] & mask_p[i]))) begin
        match_oh[i] = 1'b1;
        sel         = sel_width_p'(i);
        hit         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_axi_read_router.sv
// AXI read router: one AR to N targets by address, one outstanding burst,
// DECERR bursts generated locally for unmapped addresses.
module bp_axi_read_router
  import bp_axi_router_pkg::*;
#(
  parameter int num_targets_p = 2,
  parameter int addr_width_p  = 64,
  parameter int data_width_p  = 64,
  parameter int id_width_p    = 4,
  parameter logic [num_targets_p-1:0][addr_width_p-1:0] target_base_p = '0,
  parameter logic [num_targets_p-1:0][addr_width_p-1:0] target_mask_p = '0
) (
  input  logic                                      s_axi_aclk,
  input  logic                                      s_axi_aresetn,
  input  logic [addr_width_p-1:0]                   s_axi_araddr,
  input  logic [id_width_p-1:0]                     s_axi_arid,
  input  logic [7:0]                                s_axi_arlen,
  input  logic [2:0]                                s_axi_arsize,
  input  logic [1:0]                                s_axi_arburst,
  input  logic                                      s_axi_arvalid,
  output logic                                      s_axi_arready,
  output logic [data_width_p-1:0]                   s_axi_rdata,
  output logic [id_width_p-1:0]                     s_axi_rid,
  output logic [1:0]                                s_axi_rresp,
  output logic                                      s_axi_rlast,
  output logic                                      s_axi_rvalid,
  input  logic                                      s_axi_rready,
  output logic [addr_width_p-1:0]                   m_axi_araddr,
  output logic [id_width_p-1:0]                     m_axi_arid,
  output logic [7:0]                                m_axi_arlen,
  output logic [2:0]                                m_axi_arsize,
  output logic [1:0]                                m_axi_arburst,
  output logic [num_targets_p-1:0]                  m_axi_arvalid,
  input  logic [num_targets_p-1:0]                  m_axi_arready,
  input  logic [num_targets_p-1:0][data_width_p-1:0] m_axi_rdata,
  input  logic [num_targets_p-1:0][id_width_p-1:0]  m_axi_rid,
  input  logic [num_targets_p-1:0][1:0]             m_axi_rresp,
  input  logic [num_targets_p-1:0]                  m_axi_rlast,
  input  logic [num_targets_p-1:0]                  m_axi_rvalid,
  output logic [num_targets_p-1:0]                  m_axi_rready
);

  localparam int sel_width_lp = (num_targets_p > 1) ? $clog2(num_targets_p) : 1;

  state_e                  state_r, state_n;
  logic [sel_width_lp-1:0] sel_r, sel_n;
  logic [id_width_p-1:0]   id_r, id_n;
  logic [7:0]              len_r, len_n;
  logic [7:0]              cnt_r, cnt_n;

  logic [num_targets_p-1:0] dec_match;
  logic [sel_width_lp-1:0]  dec_sel;
  logic                     dec_hit;

  bp_axi_addr_decode #(
    .num_targets_p(num_targets_p),
    .addr_width_p (addr_width_p),
    .sel_width_p  (sel_width_lp),
    .base_p       (target_base_p),
    .mask_p       (target_mask_p)
  ) u_decode (
    .addr    (s_axi_araddr),
    .match_oh(dec_match),
    .sel     (dec_sel),
    .hit     (dec_hit)
  );

  // AR payload is broadcast; only the arvalid bits steer the request.
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;

  always_comb begin
    state_n       = state_r;
    sel_n         = sel_r;
    id_n          = id_r;
    len_n         = len_r;
    cnt_n         = cnt_r;
    s_axi_arready = 1'b0;
    m_axi_arvalid = '0;
    m_axi_rready  = '0;
    s_axi_rvalid  = 1'b0;
    s_axi_rdata   = '0;
    s_axi_rid     = '0;
    s_axi_rresp   = '0;
    s_axi_rlast   = 1'b0;
    // Handshake outputs are gated so nothing is offered while reset is held.
    if (s_axi_aresetn) begin
      unique case (state_r)
        e_ready: begin
          if (dec_hit) begin
            m_axi_arvalid = dec_match & {num_targets_p{s_axi_arvalid}};
            s_axi_arready = |(dec_match & m_axi_arready);
            if (s_axi_arvalid && s_axi_arready) begin
              sel_n   = dec_sel;
              state_n = e_target;
            end
          end else begin
            s_axi_arready = 1'b1;
            if (s_axi_arvalid) begin
              id_n    = s_axi_arid;
              len_n   = s_axi_arlen;
              cnt_n   = 8'd0;
              state_n = e_decerr;
            end
          end
        end
        e_target: begin
          s_axi_rvalid        = m_axi_rvalid[sel_r];
          s_axi_rdata         = m_axi_rdata[sel_r];
          s_axi_rid           = m_axi_rid[sel_r];
          s_axi_rresp         = m_axi_rresp[sel_r];
          s_axi_rlast         = m_axi_rlast[sel_r];
          m_axi_rready[sel_r] = s_axi_rready;
          if (s_axi_rvalid && s_axi_rready && s_axi_rlast) state_n = e_ready;
        end
        e_decerr: begin
          s_axi_rvalid = 1'b1;
          s_axi_rresp  = axi_resp_decerr_lp;
          s_axi_rid    = id_r;
          s_axi_rlast  = (cnt_r == len_r);
          if (s_axi_rready) begin
            cnt_n = cnt_r + 8'd1;
            if (s_axi_rlast) state_n = e_ready;
          end
        end
        default: state_n = e_ready;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_r <= e_ready;
      sel_r   <= '0;
      id_r    <= '0;
      len_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      sel_r   <= sel_n;
      id_r    <= id_n;
      len_r   <= len_n;
      cnt_r   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bp_axi_read_router.sv
// Directed self-checking bench for bp_axi_read_router with three targets.
module tb_bp_axi_read_router;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      araddr;
  logic [3:0]       arid;
  logic [7:0]       arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic             arvalid;
  logic             arready;
  logic [63:0]      rdata;
  logic [3:0]       rid;
  logic [1:0]       rresp;
  logic             rlast;
  logic             rvalid;
  logic             rready;
  logic [63:0]      m_araddr;
  logic [3:0]       m_arid;
  logic [7:0]       m_arlen;
  logic [2:0]       m_arsize;
  logic [1:0]       m_arburst;
  logic [N-1:0]     m_arvalid;
  logic [N-1:0]     m_arready;
  logic [N-1:0][63:0] m_rdata;
  logic [N-1:0][3:0]  m_rid;
  logic [N-1:0][1:0]  m_rresp;
  logic [N-1:0]     m_rlast;
  logic [N-1:0]     m_rvalid;
  logic [N-1:0]     m_rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_axi_read_router #(
    .num_targets_p(N),
    .addr_width_p (64),
    .data_width_p (64),
    .id_width_p   (4),
    .target_base_p({64'h0000_0000_8000_0000, 64'h0000_0000_0011_0000, 64'h0}),
    .target_mask_p({64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_F000,
                    64'hFFFF_FFFF_FFFF_0000})
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .s_axi_araddr (araddr),
    .s_axi_arid   (arid),
    .s_axi_arlen  (arlen),
    .s_axi_arsize (arsize),
    .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rid    (rid),
    .s_axi_rresp  (rresp),
    .s_axi_rlast  (rlast),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .m_axi_araddr (m_araddr),
    .m_axi_arid   (m_arid),
    .m_axi_arlen  (m_arlen),
    .m_axi_arsize (m_arsize),
    .m_axi_arburst(m_arburst),
    .m_axi_arvalid(m_arvalid),
    .m_axi_arready(m_arready),
    .m_axi_rdata  (m_rdata),
    .m_axi_rid    (m_rid),
    .m_axi_rresp  (m_rresp),
    .m_axi_rlast  (m_rlast),
    .m_axi_rvalid (m_rvalid),
    .m_axi_rready (m_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int delivered;
    int beats;
    logic [4:0] rr_pat;

    rst_n = 1'b0; araddr = 64'h20_0000; arid = '0; arlen = '0; arsize = 3'd3;
    arburst = 2'b01; arvalid = 1'b1; m_arready = '0; m_rdata = '0; m_rid = '0;
    m_rresp = '0; m_rlast = '0; m_rvalid = '0; rready = 1'b0;
    #2;
    chk("rst_arready", arready, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    arvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Mapped read to target 0, 4 beats
    araddr = 64'h1234; arid = 4'd3; arlen = 8'd3; arvalid = 1'b1; m_arready = 3'b001;
    #1;
    chk("t0_m_arvalid", m_arvalid, 3'b001);
    chk("t0_arready", arready, 1);
    chk("t0_m_araddr", m_araddr, 64'h1234);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 3'b001; m_rdata[0] = 64'hA0 + 64'(b); m_rid[0] = 4'd3;
      m_rlast[0] = (b == 3);
      #1;
      chk("t0_rvalid", rvalid, 1);
      chk("t0_rdata", rdata, 64'hA0 + 64'(b));
      chk("t0_rid", rid, 3);
      chk("t0_rlast", rlast, (b == 3) ? 1 : 0);
      chk("t0_m_rready", m_rready, 3'b001);
      chk("t0_busy_arready", arready, 0);
      tick();
    end
    m_rvalid = '0; m_rlast = '0;
    #1;
    chk("t0_done_rvalid", rvalid, 0);
    chk("t0_done_ready", arready, 1);

    // Target 1 selected with target 0 not ready; then a second AR queued behind it
    araddr = 64'h11_0040; arid = 4'd1; arlen = 8'd1; arvalid = 1'b1; m_arready = 3'b010;
    #1;
    chk("t1_m_arvalid", m_arvalid, 3'b010);
    chk("t1_arready", arready, 1);
    tick();
    araddr = 64'h1234; arid = 4'd7; arlen = 8'd0; m_arready = 3'b111;
    m_rvalid = 3'b010; m_rdata[1] = 64'hB0; m_rid[1] = 4'd1; m_rlast[1] = 1'b0;
    #1;
    chk("t1_hold_arready0", arready, 0);
    chk("t1_hold_m_arvalid0", m_arvalid, 0);
    chk("t1_b0_rdata", rdata, 64'hB0);
    chk("t1_b0_m_rready", m_rready, 3'b010);
    tick();
    m_rdata[1] = 64'hB1; m_rlast[1] = 1'b1;
    #1;
    chk("t1_b1_rlast", rlast, 1);
    chk("t1_hold_arready1", arready, 0);
    tick();
    m_rvalid = '0; m_rlast = '0;
    #1;
    chk("t1_next_arready", arready, 1);
    chk("t1_next_m_arvalid", m_arvalid, 3'b001);
    tick();
    arvalid = 1'b0;
    m_rvalid = 3'b001; m_rdata[0] = 64'hC0; m_rid[0] = 4'd7; m_rlast[0] = 1'b1;
    #1;
    chk("q_rdata", rdata, 64'hC0);
    chk("q_rid", rid, 7);
    chk("q_rlast", rlast, 1);
    tick();
    m_rvalid = '0; m_rlast = '0;

    // Unmapped read: 3 DECERR beats
    araddr = 64'h20_0000; arid = 4'd5; arlen = 8'd2; arvalid = 1'b1;
    #1;
    chk("de_arready", arready, 1);
    chk("de_m_arvalid", m_arvalid, 0);
    tick();
    arvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("de_rvalid", rvalid, 1);
      chk("de_rresp", rresp, 2'b11);
      chk("de_rid", rid, 5);
      chk("de_rdata", rdata, 0);
      chk("de_rlast", rlast, (b == 2) ? 1 : 0);
      chk("de_m_arvalid_busy", m_arvalid, 0);
      tick();
    end
    #1;
    chk("de_done_rvalid", rvalid, 0);

    // DECERR under backpressure 1,0,0,1,1
    araddr = 64'h20_0000; arid = 4'd9; arlen = 8'd2; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    rr_pat = 5'b11001;
    beats = 0; delivered = 0;
    for (int c = 0; c < 5; c++) begin
      rready = rr_pat[c];
      #1;
      chk("bp_rvalid", rvalid, 1);
      chk("bp_rid", rid, 9);
      chk("bp_rresp", rresp, 2'b11);
      chk("bp_rdata", rdata, 0);
      chk("bp_rlast", rlast, (beats == 2) ? 1 : 0);
      if (rvalid && rready) delivered++;
      if (rready) beats++;
      tick();
    end
    chk("bp_delivered", 64'(delivered), 3);
    #1;
    chk("bp_done_rvalid", rvalid, 0);
    rready = 1'b1;

    // Reset mid-burst on target 2
    araddr = 64'h8000_1000; arid = 4'd2; arlen = 8'd3; arvalid = 1'b1; m_arready = 3'b100;
    #1;
    chk("t2_m_arvalid", m_arvalid, 3'b100);
    tick();
    arvalid = 1'b0;
    m_rvalid = 3'b100; m_rdata[2] = 64'hD0; m_rid[2] = 4'd2; m_rlast[2] = 1'b0;
    #1;
    chk("t2_b0_rvalid", rvalid, 1);
    chk("t2_b0_m_rready", m_rready, 3'b100);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t2_rst_rvalid", rvalid, 0);
    chk("t2_rst_m_rready", m_rready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t2_post_rvalid", rvalid, 0);
    chk("t2_post_m_rready", m_rready, 0);
    chk("t2_post_ready", arready, 1);
    tick();
    #1;
    chk("t2_post2_rvalid", rvalid, 0);
    m_rvalid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
